// File: rtl/scpu_hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scpu_hazard_pkg
//  Description : Shared types and constants for the SCPU hazard sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package scpu_hazard_pkg;

    // Hazard sequencer states; encoding 3 is never entered and recovers to RUN
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_LU_STALL = 2'd2,
        ST_RSVD     = 2'd3
    } hz_state_e;

    // Canonical NOP (addi x0, x0, 0) substituted into ID when killed
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Hard-wired zero register; writes to it never create a dependency
    localparam logic [4:0]  REG_X0   = 5'd0;

endpackage : scpu_hazard_pkg
`default_nettype wire

// File: rtl/hazard_event_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_event_counter
//  Description : Free-running event counter, wraps modulo 2^CNT_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority, otherwise increment with natural wrap
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : hazard_event_counter
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : SCPU hazard sequencer - control-flow flush shadow, load-use
//                interlock and external stall freeze, with event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import scpu_hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int LU_CYCLES    = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_stall,
    input  logic             ex_branch_taken,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             id_kill,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    // Reload values: the accepting cycle itself is the first kill/stall cycle
    localparam logic [2:0] SHADOW_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [1:0] LU_LOAD     = 2'(LU_CYCLES - 1);
    localparam hz_state_e  BR_NEXT     = (FLUSH_CYCLES > 1) ? ST_FLUSH    : ST_RUN;
    localparam hz_state_e  LU_NEXT     = (LU_CYCLES > 1)    ? ST_LU_STALL : ST_RUN;

    hz_state_e  state_q, state_d;
    logic [2:0] shadow_q, shadow_d;
    logic [1:0] lu_q, lu_d;
    logic       lu_hit;
    logic       flush_inc;
    logic       stall_inc;

    assign lu_hit = ex_mem_read && (ex_rd != REG_X0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

    // Next-state and zero-latency hold/kill decode; priority rst > ext_stall > branch > load-use
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        lu_d        = lu_q;
        id_kill     = 1'b0;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        flush_inc   = 1'b0;
        stall_inc   = 1'b0;

        if (rst) begin
            // outputs forced low while reset is asserted
        end else if (ext_stall) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            id_kill   = (state_q == ST_FLUSH);
        end else if (state_q == ST_RSVD) begin
            state_d = ST_RUN;
        end else if (ex_branch_taken) begin
            id_kill   = 1'b1;
            shadow_d  = SHADOW_LOAD;
            flush_inc = 1'b1;
            state_d   = BR_NEXT;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    id_kill  = 1'b1;
                    shadow_d = shadow_q - 3'd1;
                    if (shadow_q == 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
                ST_LU_STALL: begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                    lu_d        = lu_q - 2'd1;
                    if (lu_q == 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (lu_hit) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                        lu_d        = LU_LOAD;
                        state_d     = LU_NEXT;
                    end
                end
            endcase
        end
    end

    // State and shadow/stall down-counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            shadow_q <= 3'd0;
            lu_q     <= 2'd0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            lu_q     <= lu_d;
        end
    end

    assign hz_state = state_q;

    hazard_event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_inc),
        .clear (1'b0),
        .count (flush_cnt)
    );

    hazard_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_inc),
        .clear (1'b0),
        .count (stall_cnt)
    );

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Scoreboard bench for pipeline_hazard_ctrl; two configurations
//                (defaults, and FLUSH=3/LU=2/CNT_W=4) driven in parallel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       ext_stall = 1'b0, br = 1'b0, mr = 1'b0, u1 = 1'b0, u2 = 1'b0;
    logic [4:0] ex_rd = 5'd0, id_rs1 = 5'd0, id_rs2 = 5'd0;

    logic        kill_a, pc_a, ifid_a, bub_a, kill_b, pc_b, ifid_b, bub_b;
    logic [1:0]  st_a, st_b;
    logic [31:0] fc_a, sc_a;
    logic [3:0]  fc_b, sc_b;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .LU_CYCLES(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .ext_stall(ext_stall), .ex_branch_taken(br),
        .ex_mem_read(mr), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(u1), .id_use_rs2(u2), .id_kill(kill_a), .pc_hold(pc_a),
        .ifid_hold(ifid_a), .idex_bubble(bub_a), .hz_state(st_a),
        .flush_cnt(fc_a), .stall_cnt(sc_a)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .LU_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .ext_stall(ext_stall), .ex_branch_taken(br),
        .ex_mem_read(mr), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(u1), .id_use_rs2(u2), .id_kill(kill_b), .pc_hold(pc_b),
        .ifid_hold(ifid_b), .idex_bubble(bub_b), .hz_state(st_b),
        .flush_cnt(fc_b), .stall_cnt(sc_b)
    );

    typedef struct {
        logic            kill, pc, ifid, bub;
        logic [1:0]      st;
        longint unsigned fc, sc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int tests = 0;
    int fails = 0;

    // Reference model: cycles of kill / stall still owed, and event totals
    int              PF[2]   = '{2, 3};
    int              PL[2]   = '{1, 2};
    longint unsigned MASK[2] = '{64'hFFFF_FFFF, 64'hF};
    int              kill_left[2]  = '{0, 0};
    int              stall_left[2] = '{0, 0};
    longint unsigned nflush[2] = '{0, 0};
    longint unsigned nstall[2] = '{0, 0};

    task automatic model_step(input int k, output exp_t e);
        logic hit;
        hit = mr && (ex_rd != 5'd0) &&
              ((u1 && ex_rd == id_rs1) || (u2 && ex_rd == id_rs2));
        e.kill = 1'b0; e.pc = 1'b0; e.ifid = 1'b0; e.bub = 1'b0;
        e.st = (kill_left[k] > 0) ? 2'd1 : (stall_left[k] > 0) ? 2'd2 : 2'd0;
        e.fc = nflush[k];
        e.sc = nstall[k];
        if (rst) begin
            e.st = 2'd0; e.fc = 0; e.sc = 0;
            kill_left[k] = 0; stall_left[k] = 0; nflush[k] = 0; nstall[k] = 0;
        end else if (ext_stall) begin
            e.pc = 1'b1; e.ifid = 1'b1;
            e.kill = (kill_left[k] > 0);
        end else if (br) begin
            e.kill = 1'b1;
            kill_left[k]  = PF[k] - 1;
            stall_left[k] = 0;
            nflush[k] = (nflush[k] + 1) & MASK[k];
        end else if (kill_left[k] > 0) begin
            e.kill = 1'b1;
            kill_left[k]--;
        end else if (stall_left[k] > 0 || hit) begin
            e.pc = 1'b1; e.ifid = 1'b1; e.bub = 1'b1;
            nstall[k] = (nstall[k] + 1) & MASK[k];
            stall_left[k] = (stall_left[k] > 0) ? stall_left[k] - 1 : PL[k] - 1;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic b, input logic m,
                        input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2,
                        input logic a1, input logic a2);
        exp_t ea, eb;
        @(posedge clk);
        #1;
        rst = r; ext_stall = e; br = b; mr = m;
        ex_rd = rd; id_rs1 = s1; id_rs2 = s2; u1 = a1; u2 = a2;
        model_step(0, ea);
        model_step(1, eb);
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are compared mid-cycle against the expectation for that cycle
    always @(negedge clk) begin : mon
        exp_t ea, eb;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_id_kill",     64'(kill_a), 64'(ea.kill));
            chk("a_pc_hold",     64'(pc_a),   64'(ea.pc));
            chk("a_ifid_hold",   64'(ifid_a), 64'(ea.ifid));
            chk("a_idex_bubble", 64'(bub_a),  64'(ea.bub));
            chk("a_hz_state",    64'(st_a),   64'(ea.st));
            chk("a_flush_cnt",   64'(fc_a),   ea.fc);
            chk("a_stall_cnt",   64'(sc_a),   ea.sc);
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_id_kill",     64'(kill_b), 64'(eb.kill));
            chk("b_pc_hold",     64'(pc_b),   64'(eb.pc));
            chk("b_ifid_hold",   64'(ifid_b), 64'(eb.ifid));
            chk("b_idex_bubble", 64'(bub_b),  64'(eb.bub));
            chk("b_hz_state",    64'(st_b),   64'(eb.st));
            chk("b_flush_cnt",   64'(fc_b),   eb.fc);
            chk("b_stall_cnt",   64'(sc_b),   eb.sc);
        end
    end

    initial begin
        // reset, then idle
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(4);
        // single taken branch
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(4);
        // load-use on rs2, then the same with x0 as destination
        step(0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1);
        idle(3);
        step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        idle(3);
        // ext_stall for 3 cycles inside the flush shadow
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(0, 1, 1, 1, 5'd3, 5'd3, 5'd0, 1, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(4);
        // back-to-back branches
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(4);
        // branch arriving during the load-use stall
        step(0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 1, 0);
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(4);
        // reset pulse mid-flush, branch input still high
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(3);
        // 16 redirects: 4-bit counter wraps to 0
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(4);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 40),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(2);
        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
        @(negedge clk);
        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending expected 0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
